ext_mem_arbiter: RTL
====================

Name: ext_mem_arbiter

Overview:
Shares the single external-memory read port and write port between NB_REQ on-chip requesters. Examples of requesters: the controller's partial-sum read/writeback stream, and an output drain/debug reader. Read and write ports are arbitrated independently with round-robin fairness. Memory-side signals are registered. Read data is returned to the issuing requester with a one-hot response strobe. The block sits between requesters and the top-level ext_mem_* pins of top_chip.

Parameters:
NB_REQ, 2, number of requesters (2..8)
ADDR_WIDTH, 20, external memory address width (= $clog2(EXT_MEM_HEIGHT))
DATA_WIDTH, 32, external memory word width (= EXT_MEM_WIDTH)

Ports:
clk  in  1  clock
arst_n_in  in  1  asynchronous reset, active low
req_valid  in  NB_REQ  per-requester request valid
req_ready  out  NB_REQ  per-requester accept (grant)
req_we  in  NB_REQ  1 = write request, 0 = read request
req_addr  in  NB_REQ*ADDR_WIDTH  per-requester address, packed, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
req_wdata  in  NB_REQ*DATA_WIDTH  per-requester write data, packed likewise
rsp_valid  out  NB_REQ  one-hot read-data-valid strobe
rsp_data  out  DATA_WIDTH  read data, shared by all requesters
ext_mem_read_addr  out  ADDR_WIDTH  memory read address (registered)
ext_mem_read_en  out  1  memory read enable (registered)
ext_mem_qout  in  DATA_WIDTH  memory read data, valid 1 cycle after read_en
ext_mem_write_addr  out  ADDR_WIDTH  memory write address (registered)
ext_mem_din  out  DATA_WIDTH  memory write data (registered)
ext_mem_write_en  out  1  memory write enable (registered)

Behaviour:
- Handshake: a request transfers in cycle t when req_valid[i] && req_ready[i]. req_ready is combinational from req_valid, req_we and the priority pointers. At most one read grant and one write grant per cycle; they go to different requesters. A requester presents only one request per cycle.
- Read arbitration: candidates are i with req_valid[i] && !req_we[i]. Grant the first candidate at or after rd_ptr, scanning upward modulo NB_REQ. After a read grant to i, rd_ptr <= (i+1) mod NB_REQ. With no grant, rd_ptr holds.
- Write arbitration: identical, over req_we[i]=1 candidates, with its own wr_ptr.
- Issue, cycle t+1:
  - read grant at t: ext_mem_read_en=1 and ext_mem_read_addr=granted addr; otherwise read_en=0 and read_addr holds.
  - write grant at t: ext_mem_write_en=1, with write_addr/din = granted values; otherwise write_en=0 and addr/din hold.
- Response, cycle t+2: rsp_valid = one-hot of the read requester granted at t. rsp_data = ext_mem_qout (combinational pass-through). When no response is due, rsp_valid = 0 and rsp_data is don't-care.
- Throughput: back-to-back reads and writes, one of each per cycle. No stall path; requesters must always accept a response.
- Latency: read request accept to rsp_valid = 2 cycles. Write accept to ext_mem_write_en = 1 cycle.
- Ordering/hazards: no forwarding.
  - A read and a write to the same address issued in the same cycle return memory's pre-write data.
  - Ordering between requesters is the requesters' responsibility.
  - Responses to one requester arrive in issue order.
- Reset (arst_n_in low, any time): all registers cleared immediately.
  - rd_ptr = wr_ptr = 0
  - ext_mem_read_en = ext_mem_write_en = 0
  - ext_mem_read_addr = ext_mem_write_addr = ext_mem_din = 0
  - rsp_valid pipeline = 0
  - In-flight reads are dropped; no rsp_valid follows reset release.
  - req_ready may be combinationally high during reset, but accepts during reset are discarded.
- Idle: all req_valid low -> req_ready = 0, ptrs hold, enables 0 next cycle.

Decomposition:
- Package ext_mem_pkg:
  - ADDR_WIDTH/DATA_WIDTH defaults
  - typedefs ext_addr_t and ext_data_t
  - typedef req_id_t = logic[$clog2(NB_REQ)-1:0]
- Sub-module rr_arbiter (params NB_REQ):
  - inputs: clk, arst_n_in, request vector, advance
  - outputs: one-hot grant, grant id
  - owns its priority pointer
  - instantiated twice, for read and write.
- The top level holds the issue registers and the 2-stage response id/valid shift register.

Test Plan:
- Reset then idle, all req_valid=0 for 10 cycles -> read_en=write_en=0, rsp_valid=0, all memory outputs 0.
- Req0 read addr 0x00010 at t, memory model returns 0xDEADBEEF -> read_en=1 with addr 0x00010 at t+1; rsp_valid=2'b01 with rsp_data=0xDEADBEEF at t+2.
- Both requesters read continuously for 6 cycles -> grants alternate 0,1,0,1,0,1 (ptr starts 0); rsp_valid follows 2 cycles later in the same order.
- Req0 writes 0x5 to addr 0x20 while req1 reads addr 0x30 in the same cycle -> both ready=1; next cycle write_en=1 (0x20, 0x5) and read_en=1 (0x30); rsp_valid=2'b10 at t+2.
- Both requesters write simultaneously for 3 cycles starting with wr_ptr=1 -> write grant order 1,0,1; read port stays idle; rd_ptr unchanged.
- Read granted at t, arst_n_in pulsed low at t+1 -> read_en=0 immediately; no rsp_valid at t+2; after release, a new read completes with the normal 2-cycle latency.

Source files
------------

// File: rtl/ext_mem_arbiter_pkg.sv
// Shared types and defaults for the external-memory port arbiter.
package ext_mem_pkg;

  localparam int EXT_ADDR_WIDTH = 20;
  localparam int EXT_DATA_WIDTH = 32;
  localparam int NB_REQ_DEF     = 2;

  typedef logic [EXT_ADDR_WIDTH-1:0]     ext_addr_t;
  typedef logic [EXT_DATA_WIDTH-1:0]     ext_data_t;
  typedef logic [$clog2(NB_REQ_DEF)-1:0] req_id_t;

  // Width of a requester index; never zero, even for a single requester.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ext_mem_arbiter_if.sv
// Requester-side and memory-side bus of the external-memory arbiter.
//
// Handshake: requester i transfers a request in the cycle where
// req_valid[i] && req_ready[i]. req_ready is combinational from req_valid,
// req_we and the arbiter pointers, so a requester must hold its request
// stable until it sees ready. Responses (rsp_valid one-hot) have no
// back-pressure: requesters always accept them.
interface ext_mem_arbiter_if #(
  parameter int NB_REQ     = ext_mem_pkg::NB_REQ_DEF,
  parameter int ADDR_WIDTH = ext_mem_pkg::EXT_ADDR_WIDTH,
  parameter int DATA_WIDTH = ext_mem_pkg::EXT_DATA_WIDTH
) ();

  logic [NB_REQ-1:0]            req_valid;
  logic [NB_REQ-1:0]            req_ready;
  logic [NB_REQ-1:0]            req_we;
  logic [NB_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NB_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NB_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]        rsp_data;
  logic [ADDR_WIDTH-1:0]        ext_mem_read_addr;
  logic                         ext_mem_read_en;
  logic [DATA_WIDTH-1:0]        ext_mem_qout;
  logic [ADDR_WIDTH-1:0]        ext_mem_write_addr;
  logic [DATA_WIDTH-1:0]        ext_mem_din;
  logic                         ext_mem_write_en;

  // Arbiter view.
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, ext_mem_qout,
    output req_ready, rsp_valid, rsp_data,
           ext_mem_read_addr, ext_mem_read_en,
           ext_mem_write_addr, ext_mem_din, ext_mem_write_en
  );

  // Requesters plus memory view.
  modport master (
    output req_valid, req_we, req_addr, req_wdata, ext_mem_qout,
    input  req_ready, rsp_valid, rsp_data,
           ext_mem_read_addr, ext_mem_read_en,
           ext_mem_write_addr, ext_mem_din, ext_mem_write_en
  );

endinterface

// File: rtl/ext_mem_arbiter_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// then moves the pointer just past the winner.
module rr_arbiter import ext_mem_pkg::*; #(
  parameter int NB_REQ = NB_REQ_DEF
) (
  input  logic                        clk,
  input  logic                        arst_n_in,
  input  logic [NB_REQ-1:0]           req_i,
  input  logic                        advance_i,
  output logic [NB_REQ-1:0]           gnt_o,
  output logic [id_width(NB_REQ)-1:0] gnt_id_o
);

  localparam int ID_W = id_width(NB_REQ);

  logic [ID_W-1:0] ptr_q, ptr_d;
  logic            found;
  int              idx;

  // Scan upward from the pointer, wrapping modulo NB_REQ.
  always_comb begin
    gnt_o    = '0;
    gnt_id_o = '0;
    found    = 1'b0;
    idx      = 0;
    for (int i = 0; i < NB_REQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NB_REQ) idx = idx - NB_REQ;
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_id_o   = ID_W'(idx);
      end
    end
  end

  // Pointer moves one past the winner; holds when nothing is granted.
  always_comb begin
    ptr_d = ptr_q;
    if (advance_i && found) begin
      if (gnt_id_o == ID_W'(NB_REQ - 1)) ptr_d = '0;
      else                               ptr_d = gnt_id_o + 1'b1;
    end
  end

  // Priority pointer register.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) ptr_q <= '0;
    else            ptr_q <= ptr_d;
  end

endmodule

// File: rtl/ext_mem_arbiter.sv
// Shares one external-memory read port and one write port between NB_REQ
// requesters. Ports are arbitrated independently; memory-side signals are
// registered and read data returns two cycles after accept.
module ext_mem_arbiter import ext_mem_pkg::*; #(
  parameter int NB_REQ     = NB_REQ_DEF,
  parameter int ADDR_WIDTH = EXT_ADDR_WIDTH,
  parameter int DATA_WIDTH = EXT_DATA_WIDTH
) (
  input logic              clk,
  input logic              arst_n_in,
  ext_mem_arbiter_if.slave bus
);

  localparam int ID_W = id_width(NB_REQ);

  logic [NB_REQ-1:0]     rd_req, wr_req, rd_gnt, wr_gnt;
  logic [ID_W-1:0]       rd_id, wr_id;
  logic [ADDR_WIDTH-1:0] rd_addr_sel, wr_addr_sel;
  logic [DATA_WIDTH-1:0] wr_data_sel;

  logic                  rd_en_q, rd_en_d, wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  // Response pipeline: stage 1 valid is rd_en_q itself.
  logic [ID_W-1:0]       rsp_id1_q, rsp_id1_d, rsp_id2_q, rsp_id2_d;
  logic                  rsp_v2_q, rsp_v2_d;

  assign rd_req = bus.req_valid & ~bus.req_we;
  assign wr_req = bus.req_valid &  bus.req_we;

  rr_arbiter #(.NB_REQ(NB_REQ)) u_rd_arb (
    .clk       (clk),
    .arst_n_in (arst_n_in),
    .req_i     (rd_req),
    .advance_i (1'b1),
    .gnt_o     (rd_gnt),
    .gnt_id_o  (rd_id)
  );

  rr_arbiter #(.NB_REQ(NB_REQ)) u_wr_arb (
    .clk       (clk),
    .arst_n_in (arst_n_in),
    .req_i     (wr_req),
    .advance_i (1'b1),
    .gnt_o     (wr_gnt),
    .gnt_id_o  (wr_id)
  );

  // A requester issues one kind of request per cycle, so the grants never collide.
  assign bus.req_ready = rd_gnt | wr_gnt;

  // Select the granted requester's address/data via the one-hot grants.
  always_comb begin
    rd_addr_sel = '0;
    wr_addr_sel = '0;
    wr_data_sel = '0;
    for (int i = 0; i < NB_REQ; i++) begin
      if (rd_gnt[i]) rd_addr_sel = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      if (wr_gnt[i]) begin
        wr_addr_sel = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        wr_data_sel = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Issue and response next-state: addresses/data hold when idle.
  always_comb begin
    rd_en_d   = |rd_gnt;
    rd_addr_d = (|rd_gnt) ? rd_addr_sel : rd_addr_q;
    wr_en_d   = |wr_gnt;
    wr_addr_d = (|wr_gnt) ? wr_addr_sel : wr_addr_q;
    din_d     = (|wr_gnt) ? wr_data_sel : din_q;
    rsp_id1_d = rd_id;
    rsp_v2_d  = rd_en_q;
    rsp_id2_d = rsp_id1_q;
  end

  // Issue registers and response shift register; reset drops in-flight reads.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      din_q     <= '0;
      rsp_id1_q <= '0;
      rsp_v2_q  <= 1'b0;
      rsp_id2_q <= '0;
    end else begin
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      din_q     <= din_d;
      rsp_id1_q <= rsp_id1_d;
      rsp_v2_q  <= rsp_v2_d;
      rsp_id2_q <= rsp_id2_d;
    end
  end

  // Decode the returning read's requester id into the one-hot strobe.
  always_comb begin
    bus.rsp_valid = '0;
    for (int i = 0; i < NB_REQ; i++) begin
      bus.rsp_valid[i] = rsp_v2_q && (rsp_id2_q == ID_W'(i));
    end
  end

  assign bus.rsp_data           = bus.ext_mem_qout;
  assign bus.ext_mem_read_en    = rd_en_q;
  assign bus.ext_mem_read_addr  = rd_addr_q;
  assign bus.ext_mem_write_en   = wr_en_q;
  assign bus.ext_mem_write_addr = wr_addr_q;
  assign bus.ext_mem_din        = din_q;

endmodule
